// File: rtl/step_pulse_gen_if.sv
// Step pulse interface: enable/mode control in,
// pulse stream and window status out.
interface step_pulse_gen_if;
  logic       enable;
  logic [1:0] mode;
  logic       pulse;
  logic       sec_tick;
  logic [7:0] sec_num;
  logic [7:0] step_cnt;

  modport master (
    input  enable,
    input  mode,
    output pulse,
    output sec_tick,
    output sec_num,
    output step_cnt
  );

  modport slave (
    output enable,
    output mode,
    input  pulse,
    input  sec_tick,
    input  sec_num,
    input  step_cnt
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Step pulse generator: exact steps per one-second window.
// Define STEP_HYBRID_EN to enable the scripted hybrid profile on mode 11.
module step_pulse_gen #(
  parameter int CLK_HZ  = 100000000,
  parameter int PULSE_W = 4
) (
  input  logic              CLK,
  input  logic              reset,
  step_pulse_gen_if.master  sp
);

  localparam int ACC_W = $clog2(CLK_HZ + 256);
  localparam int CYC_W = $clog2(CLK_HZ);
  localparam int PW_W  = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CYC_W-1:0]   r_cyc;
  logic [ACC_W-1:0]   r_acc;
  logic [7:0]         r_rate;
  logic [7:0]         r_sec_num;
  logic [7:0]         r_step_cnt;
  logic               r_pulse;
  logic [PW_W-1:0]    r_pw;

  logic [ACC_W-1:0]   w_acc_next;
  logic               w_tick;
  logic               w_fire;
  logic [7:0]         w_step_cnt;
  logic [7:0]         w_sec_next;
  logic [7:0]         w_rate_load;

`ifdef STEP_HYBRID_EN
  logic [7:0]         w_sec_load;

  function automatic logic [7:0] f_hybrid(input logic [7:0] n);
    logic [7:0] r;
    unique case (n)
      8'd0:    r = 8'd20;
      8'd1:    r = 8'd33;
      8'd2:    r = 8'd66;
      8'd3:    r = 8'd27;
      8'd4:    r = 8'd70;
      8'd5:    r = 8'd30;
      8'd6:    r = 8'd19;
      8'd7:    r = 8'd30;
      8'd8:    r = 8'd33;
      default: r = 8'd69;
    endcase
    return r;
  endfunction

  // Window index seen by the rate load: 0 on entry, next count at a boundary
  assign w_sec_load = (r_state == S_IDLE) ? 8'd0 : w_sec_next;
`endif

  assign w_acc_next = r_acc + ACC_W'(r_rate);
  assign w_tick     = (r_state == S_RUN) &&
                      (r_cyc == CYC_W'(CLK_HZ - 1));
  assign w_fire     = (r_state == S_RUN) && sp.enable &&
                      (w_acc_next >= ACC_W'(CLK_HZ));
  assign w_step_cnt = r_step_cnt + {7'd0, w_fire};
  assign w_sec_next = (r_sec_num == 8'hFF) ? r_sec_num
                                           : r_sec_num + 8'd1;

  always_comb begin
    w_rate_load = 8'd0;
    unique case (sp.mode)
      2'b00:   w_rate_load = 8'd32;
      2'b01:   w_rate_load = 8'd64;
      2'b10:   w_rate_load = 8'd128;
      default: begin
`ifdef STEP_HYBRID_EN
        w_rate_load = f_hybrid(w_sec_load);
`else
        w_rate_load = 8'd0;
`endif
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (sp.enable)  w_state_next = S_RUN;
      S_RUN:   if (!sp.enable) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_cyc      <= '0;
      r_acc      <= '0;
      r_rate     <= '0;
      r_sec_num  <= '0;
      r_step_cnt <= '0;
      r_pulse    <= 1'b0;
      r_pw       <= '0;
    end else if (r_state == S_IDLE || !sp.enable) begin
      r_cyc      <= '0;
      r_acc      <= '0;
      r_sec_num  <= '0;
      r_step_cnt <= '0;
      r_pulse    <= 1'b0;
      r_pw       <= '0;
      r_rate     <= (r_state == S_IDLE && sp.enable) ? w_rate_load
                                                     : 8'd0;
    end else begin
      if (w_tick) begin
        r_cyc      <= '0;
        r_acc      <= '0;
        r_step_cnt <= '0;
        r_sec_num  <= w_sec_next;
        r_rate     <= w_rate_load;
      end else begin
        r_cyc      <= r_cyc + CYC_W'(1);
        r_step_cnt <= w_step_cnt;
        r_acc      <= w_fire ? w_acc_next - ACC_W'(CLK_HZ)
                             : w_acc_next;
      end
      // Pulse shaping runs independently of the window boundary
      if (w_fire) begin
        r_pulse <= 1'b1;
        r_pw    <= PW_W'(PULSE_W - 1);
      end else if (r_pulse) begin
        if (r_pw == '0) r_pulse <= 1'b0;
        else            r_pw    <= r_pw - PW_W'(1);
      end
    end
  end

  assign sp.pulse    = r_pulse;
  assign sp.sec_tick = w_tick;
  assign sp.sec_num  = r_sec_num;
  assign sp.step_cnt = w_step_cnt;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: per-window step counts via a
// scoreboard queue, pulse shape, reset and enable corner cases.
module tb_step_pulse_gen;
  localparam int HZ = 1000;
  localparam int PW = 4;
`ifdef STEP_HYBRID_EN
  localparam bit HYB = 1'b1;
`else
  localparam bit HYB = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset;
  step_pulse_gen_if sp ();

  step_pulse_gen #(
    .CLK_HZ  (HZ),
    .PULSE_W (PW)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .sp    (sp)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int win;
  int t, rises, last_rise, min_gap, hlen, bad_w;
  bit prev_p;

  function automatic int hyb(input int n);
    int tbl [10];
    tbl = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 69};
    return (n >= 9) ? 69 : tbl[n];
  endfunction

  function automatic int model_rate(input logic [1:0] m, input int n);
    int r;
    r = 0;
    case (m)
      2'b00:   r = 32;
      2'b01:   r = 64;
      2'b10:   r = 128;
      default: r = HYB ? hyb(n) : 0;
    endcase
    return r;
  endfunction

  task automatic sample();
    @(negedge CLK);
    t++;
    if (sp.pulse && !prev_p) begin
      rises++;
      if (last_rise >= 0 && (t - last_rise) < min_gap)
        min_gap = t - last_rise;
      last_rise = t;
    end
    if (sp.pulse) hlen++;
    if (!sp.pulse && prev_p) begin
      if (hlen != PW) bad_w++;
      hlen = 0;
    end
    prev_p = sp.pulse;
  endtask

  task automatic clear_track();
    t = 0; rises = 0; last_rise = -1;
    min_gap = 1 << 30; hlen = 0; bad_w = 0; prev_p = 1'b0;
  endtask

  // Leaves the bench at the falling edge of window 0, cycle 0
  task automatic start(input logic [1:0] m);
    reset = 1'b1;
    sp.enable = 1'b0;
    sp.mode = m;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    sp.enable = 1'b1;
    win = 0;
    exp_q.delete();
    clear_track();
    sample();
  endtask

  // Runs from cycle 0 of a window to cycle 0 of the next
  task automatic run_window(input int chg_at, input logic [1:0] chg_m,
                            input bit drop, output int edges,
                            output int tick_cnt, output int sec_after,
                            output bit to);
    int r0;
    exp_q.push_back(model_rate(sp.mode, win));
    r0 = rises;
    to = 1'b1;
    tick_cnt = -1;
    sec_after = -1;
    for (int k = 1; k <= HZ + 50; k++) begin
      if (k == chg_at) sp.mode = chg_m;
      sample();
      if (sp.sec_tick) begin
        tick_cnt = sp.step_cnt;
        if (drop) sp.enable = 1'b0;
        sample();
        sec_after = sp.sec_num;
        to = 1'b0;
        break;
      end
    end
    edges = rises - r0;
    if (drop) win = 0;
    else if (win < 255) win++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sp.enable = 1'b1;
    sp.mode = 2'b00;
    repeat (3) @(negedge CLK);
    checks++;
    if (sp.pulse !== 1'b0) begin
      errors++; $display("FAIL reset_pulse: got %0b want 0", sp.pulse);
    end
    checks++;
    if (sp.sec_tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick: got %0b want 0", sp.sec_tick);
    end
    checks++;
    if (sp.sec_num !== 8'd0) begin
      errors++; $display("FAIL reset_sec: got %0d want 0", sp.sec_num);
    end
    checks++;
    if (sp.step_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", sp.step_cnt);
    end
  endtask

  task automatic test_walk();
    int e, tc, sa, ex;
    bit to;
    start(2'b00);
    run_window(0, 2'b00, 1'b0, e, tc, sa, to);
    ex = exp_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL walk_timeout: no sec_tick"); end
    checks++;
    if (e != ex) begin
      errors++; $display("FAIL walk_edges: got %0d want %0d", e, ex);
    end
    checks++;
    if (tc != ex) begin
      errors++; $display("FAIL walk_stepcnt: got %0d want %0d", tc, ex);
    end
    checks++;
    if (sa != 1) begin
      errors++; $display("FAIL walk_secnum: got %0d want 1", sa);
    end
  endtask

  task automatic test_run();
    int e, tc, sa, ex;
    bit to;
    start(2'b10);
    for (int w = 0; w < 2; w++) begin
      run_window(0, 2'b10, 1'b0, e, tc, sa, to);
      ex = exp_q.pop_front();
      checks++;
      if (to || e != ex) begin
        errors++;
        $display("FAIL run_edges w%0d: got %0d want %0d", w, e, ex);
      end
      checks++;
      if (tc != ex) begin
        errors++;
        $display("FAIL run_stepcnt w%0d: got %0d want %0d", w, tc, ex);
      end
    end
    checks++;
    if (sa != 2) begin
      errors++; $display("FAIL run_secnum: got %0d want 2", sa);
    end
    checks++;
    if (bad_w != 0) begin
      errors++; $display("FAIL run_width: %0d pulses not %0d wide", bad_w, PW);
    end
    checks++;
    if (min_gap != 7) begin
      errors++; $display("FAIL run_gap: got %0d want 7", min_gap);
    end
  endtask

  task automatic test_mode_change();
    int e, tc, sa, ex;
    bit to;
    start(2'b00);
    run_window(400, 2'b01, 1'b0, e, tc, sa, to);
    ex = exp_q.pop_front();
    checks++;
    if (to || e != ex || tc != ex) begin
      errors++;
      $display("FAIL chg_w0: edges %0d cnt %0d want %0d", e, tc, ex);
    end
    run_window(0, 2'b01, 1'b0, e, tc, sa, to);
    ex = exp_q.pop_front();
    checks++;
    if (to || e != ex || tc != ex) begin
      errors++;
      $display("FAIL chg_w1: edges %0d cnt %0d want %0d", e, tc, ex);
    end
  endtask

  task automatic test_hybrid();
    int e, tc, sa, ex;
    bit to;
    start(2'b11);
    for (int w = 0; w < 11; w++) begin
      run_window(0, 2'b11, 1'b0, e, tc, sa, to);
      ex = exp_q.pop_front();
      checks++;
      if (to || tc != ex) begin
        errors++;
        $display("FAIL hyb_cnt w%0d: got %0d want %0d", w, tc, ex);
      end
      checks++;
      if (e != ex) begin
        errors++;
        $display("FAIL hyb_edges w%0d: got %0d want %0d", w, e, ex);
      end
    end
    checks++;
    if (sa != 11) begin
      errors++; $display("FAIL hyb_secnum: got %0d want 11", sa);
    end
  endtask

  task automatic test_reset_mid();
    int e, tc, sa, ex, rise_at, tick_at;
    bit to;
    start(2'b00);
    for (int w = 0; w < 2; w++) begin
      run_window(0, 2'b00, 1'b0, e, tc, sa, to);
      ex = exp_q.pop_front();
      checks++;
      if (to || tc != ex) begin
        errors++;
        $display("FAIL rmid_pre w%0d: got %0d want %0d", w, tc, ex);
      end
    end
    repeat (500) sample();
    checks++;
    if (sp.pulse !== 1'b1) begin
      errors++; $display("FAIL rmid_high: got %0b want 1", sp.pulse);
    end
    reset = 1'b1;
    sample();
    checks++;
    if (sp.pulse !== 1'b0 || sp.sec_num !== 8'd0 || sp.step_cnt !== 8'd0)
    begin
      errors++;
      $display("FAIL rmid_clear: pulse %0b sec %0d cnt %0d want 0 0 0",
               sp.pulse, sp.sec_num, sp.step_cnt);
    end
    reset = 1'b0;
    clear_track();
    sample();
    rise_at = -1;
    tick_at = -1;
    for (int k = 1; k <= HZ + 50; k++) begin
      sample();
      if (rises > 0 && rise_at < 0) rise_at = k;
      if (sp.sec_tick) begin tick_at = k; break; end
    end
    checks++;
    if (rise_at != 32) begin
      errors++; $display("FAIL rmid_first: got %0d want 32", rise_at);
    end
    checks++;
    if (tick_at != HZ - 1) begin
      errors++; $display("FAIL rmid_tick: got %0d want %0d", tick_at, HZ - 1);
    end
  endtask

  task automatic test_enable_tick();
    int e, tc, sa, ex, rise_at;
    bit to;
    start(2'b00);
    run_window(0, 2'b00, 1'b1, e, tc, sa, to);
    ex = exp_q.pop_front();
    checks++;
    if (to || tc != ex) begin
      errors++; $display("FAIL en_cnt: got %0d want %0d", tc, ex);
    end
    checks++;
    if (sa != 0) begin
      errors++; $display("FAIL en_secnum: got %0d want 0", sa);
    end
    checks++;
    if (sp.pulse !== 1'b0) begin
      errors++; $display("FAIL en_pulse: got %0b want 0", sp.pulse);
    end
    sp.enable = 1'b1;
    clear_track();
    sample();
    rise_at = -1;
    for (int k = 1; k <= 100; k++) begin
      sample();
      if (rises > 0) begin rise_at = k; break; end
    end
    checks++;
    if (rise_at != 32) begin
      errors++; $display("FAIL en_first: got %0d want 32", rise_at);
    end
  endtask

  initial begin
    reset = 1'b1;
    sp.enable = 1'b0;
    sp.mode = 2'b00;
    test_reset();
    test_walk();
    test_run();
    test_mode_change();
    test_hybrid();
    test_reset_mid();
    test_enable_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
